sync_fifo_prog: RTL and testbench
=================================

Name: sync_fifo_prog

Overview:
Parametrised synchronous FIFO and successor to the basic sync FIFO. It adds an occupancy count, programmable almost-full and almost-empty thresholds, a read-valid strobe, and a selectable first-word-fall-through (FWFT) read mode. It sits between same-clock producer and consumer blocks as the standard rate-decoupling buffer. Overflow and underflow attempts are rejected and flagged, never corrupting state.

Parameters:
WIDTH, 8, data word width in bits (>=1)
DEPTH, 16, number of entries; power of two, >=4
PTR_WIDTH, $clog2(DEPTH), read/write pointer width
FWFT, 0, 0 = standard registered read; 1 = first-word-fall-through
AF_THRESH, DEPTH-2, almost_full asserts when count >= AF_THRESH
AE_THRESH, 2, almost_empty asserts when count <= AE_THRESH

Ports:
clk  input  1  clock; all logic on rising edge
reset  input  1  synchronous, active-high reset
wdata  input  WIDTH  write data
wr_en  input  1  write request
rd_en  input  1  read request (pop in FWFT mode)
rdata  output  WIDTH  read data
rd_valid  output  1  rdata holds a valid word
empty  output  1  count == 0
full  output  1  count == DEPTH
almost_empty  output  1  count <= AE_THRESH
almost_full  output  1  count >= AF_THRESH
count  output  PTR_WIDTH+1  current occupancy, 0..DEPTH
wr_error  output  1  one-cycle pulse: write rejected
rd_error  output  1  one-cycle pulse: read rejected

Behaviour:
- Reset (sampled at clk edge): wr_ptr=0, rd_ptr=0, count=0, empty=1, full=0, almost_empty=1, almost_full=0, rdata=0, rd_valid=0, wr_error=0, rd_error=0. Memory contents are not cleared. Reset overrides any concurrent wr_en/rd_en.
- Accepted write: wr_acc = wr_en & !full. Stores wdata at wr_ptr; wr_ptr increments.
- Accepted read: rd_acc = rd_en & !empty; rd_ptr increments.
- Acceptance uses registered flags only. A write when full is rejected even if rd_en=1 in the same cycle. A read when empty is rejected even if wr_en=1 in the same cycle.
- Pointers wrap from DEPTH-1 to 0.
- Count update: +1 on wr_acc only; -1 on rd_acc only; unchanged on both or neither. Count never leaves 0..DEPTH.
- All flags are registered from the next count value, so they change in the cycle after the causing edge.
- Errors: wr_error=1 for exactly one cycle after an edge with wr_en & full. rd_error=1 likewise after rd_en & empty. Neither changes pointers, count or memory.
- Standard mode (FWFT=0):
  - rdata is registered and loads mem[rd_ptr] on rd_acc, giving 1-cycle latency.
  - rd_valid pulses for one cycle alongside each new rdata.
  - rdata holds its value otherwise.
- FWFT mode (FWFT=1):
  - rdata = mem[rd_ptr] whenever !empty; rd_valid = !empty.
  - rd_en pops the head word.
  - A word written into an empty FIFO appears on rdata/rd_valid one cycle after its write edge.
  - rdata is 0 while empty.
- Ordering is strict FIFO in all modes, including across wrap-around and simultaneous read/write.
- Elaboration check ($error) fails unless DEPTH is a power of two >= 4 and 0 <= AE_THRESH < AF_THRESH <= DEPTH.
- Implementation: single memory array, registered pointers and flags, no combinational path from wr_en/rd_en to any output.

Test Plan:
1. Reset, then 16 writes of 0x01..0x10, with WIDTH=8, DEPTH=16 and defaults -> almost_full=1 after the 14th write, full=1 and count=16 after the 16th. empty deasserts one cycle after the first write; almost_empty deasserts once count=3.
2. At full, write 0xFF -> wr_error=1 for exactly one cycle, count stays 16. Drain 16 reads in standard mode -> rdata 0x01..0x10 in order, each with rd_valid one cycle after rd_en. Then empty=1.
3. Empty FIFO, rd_en=1 with wr_en=1 wdata=0x3C -> rd_error=1 for one cycle, rd_valid=0, count=1. A following read returns 0x3C.
4. Fill to count 5, then assert wr_en and rd_en together for 20 cycles -> count stays 5, pointers wrap, and output sequence equals input sequence delayed by 5 words.
5. FWFT=1: write 0xA5 into empty -> next cycle rdata=0xA5, rd_valid=1 with no rd_en. Pulse rd_en -> following cycle empty=1, rd_valid=0.
6. At count 7, assert reset for one cycle -> next cycle count=0, empty=1, all error/valid outputs 0. Writing 0x11 then reading returns 0x11, not stale data.

Source files
------------

// File: rtl/sync_fifo_prog.sv
// sync_fifo_prog: single-clock FIFO with occupancy count, programmable
// almost-full/almost-empty thresholds, read-valid strobe and an optional
// first-word-fall-through read port. Rejected accesses are flagged and
// leave pointers, count and memory untouched.
module sync_fifo_prog #(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 16,
    parameter int PTR_WIDTH = $clog2(DEPTH),
    parameter int FWFT      = 0,
    parameter int AF_THRESH = DEPTH - 2,
    parameter int AE_THRESH = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [WIDTH-1:0]     wdata,
    input  logic                 wr_en,
    input  logic                 rd_en,
    output logic [WIDTH-1:0]     rdata,
    output logic                 rd_valid,
    output logic                 empty,
    output logic                 full,
    output logic                 almost_empty,
    output logic                 almost_full,
    output logic [PTR_WIDTH:0]   count,
    output logic                 wr_error,
    output logic                 rd_error
);

    localparam logic [PTR_WIDTH:0] DEPTH_CNT = (PTR_WIDTH+1)'(DEPTH);
    localparam logic [PTR_WIDTH:0] AF_CNT    = (PTR_WIDTH+1)'(AF_THRESH);
    localparam logic [PTR_WIDTH:0] AE_CNT    = (PTR_WIDTH+1)'(AE_THRESH);

    // Reject illegal parameter sets at elaboration time.
    if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0 || PTR_WIDTH != $clog2(DEPTH) ||
        AE_THRESH < 0 || AE_THRESH >= AF_THRESH || AF_THRESH > DEPTH) begin : g_bad_params
        $error("sync_fifo_prog: illegal DEPTH/PTR_WIDTH/AE_THRESH/AF_THRESH");
    end

    logic [WIDTH-1:0]     mem [DEPTH];
    logic [PTR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_WIDTH:0]   count_q, count_d;
    logic                 empty_q, empty_d;
    logic                 full_q, full_d;
    logic                 ae_q, ae_d;
    logic                 af_q, af_d;
    logic                 wr_err_q, wr_err_d;
    logic                 rd_err_q, rd_err_d;
    logic                 wr_acc, rd_acc;

    // Acceptance is decided from registered flags only; count and flags
    // are computed from the post-edge occupancy.
    always_comb begin
        wr_acc   = wr_en & ~full_q;
        rd_acc   = rd_en & ~empty_q;
        wr_ptr_d = wr_ptr_q + PTR_WIDTH'(wr_acc);
        rd_ptr_d = rd_ptr_q + PTR_WIDTH'(rd_acc);
        count_d  = count_q;
        case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        empty_d  = (count_d == '0);
        full_d   = (count_d == DEPTH_CNT);
        ae_d     = (count_d <= AE_CNT);
        af_d     = (count_d >= AF_CNT);
        wr_err_d = wr_en & full_q;
        rd_err_d = rd_en & empty_q;
    end

    // Pointer, occupancy and flag registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            empty_q  <= 1'b1;
            full_q   <= 1'b0;
            ae_q     <= 1'b1;
            af_q     <= 1'b0;
            wr_err_q <= 1'b0;
            rd_err_q <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            empty_q  <= empty_d;
            full_q   <= full_d;
            ae_q     <= ae_d;
            af_q     <= af_d;
            wr_err_q <= wr_err_d;
            rd_err_q <= rd_err_d;
        end
    end

    // Storage array; contents survive reset, but reset blocks the write.
    always_ff @(posedge clk) begin
        if (!reset && wr_acc) mem[wr_ptr_q] <= wdata;
    end

    if (FWFT != 0) begin : g_fwft
        // Head word is presented directly from the array while non-empty.
        assign rdata    = empty_q ? '0 : mem[rd_ptr_q];
        assign rd_valid = ~empty_q;
    end else begin : g_std
        logic [WIDTH-1:0] rdata_q, rdata_d;
        logic             rd_valid_q, rd_valid_d;

        // Registered read: load the head on an accepted pop, else hold.
        always_comb begin
            rdata_d    = rdata_q;
            rd_valid_d = 1'b0;
            if (rd_acc) begin
                rdata_d    = mem[rd_ptr_q];
                rd_valid_d = 1'b1;
            end
        end

        // Read data and valid-strobe registers.
        always_ff @(posedge clk) begin
            if (reset) begin
                rdata_q    <= '0;
                rd_valid_q <= 1'b0;
            end else begin
                rdata_q    <= rdata_d;
                rd_valid_q <= rd_valid_d;
            end
        end

        assign rdata    = rdata_q;
        assign rd_valid = rd_valid_q;
    end

    assign empty        = empty_q;
    assign full         = full_q;
    assign almost_empty = ae_q;
    assign almost_full  = af_q;
    assign count        = count_q;
    assign wr_error     = wr_err_q;
    assign rd_error     = rd_err_q;

endmodule

// File: tb/tb_sync_fifo_prog.sv
// tb_sync_fifo_prog: drives a standard-mode and an FWFT-mode FIFO with the
// same stimulus; a queue model predicts every output after every edge.
module tb_sync_fifo_prog;

    localparam int W = 8;
    localparam int D = 16;

    logic         clk, reset, wr_en, rd_en;
    logic [W-1:0] wdata;

    logic [W-1:0] s_rdata, f_rdata;
    logic         s_rv, s_empty, s_full, s_ae, s_af, s_werr, s_rerr;
    logic         f_rv, f_empty, f_full, f_ae, f_af, f_werr, f_rerr;
    logic [4:0]   s_count, f_count;

    sync_fifo_prog #(.WIDTH(W), .DEPTH(D), .FWFT(0)) u_std (
        .clk(clk), .reset(reset), .wdata(wdata), .wr_en(wr_en), .rd_en(rd_en),
        .rdata(s_rdata), .rd_valid(s_rv), .empty(s_empty), .full(s_full),
        .almost_empty(s_ae), .almost_full(s_af), .count(s_count),
        .wr_error(s_werr), .rd_error(s_rerr));

    sync_fifo_prog #(.WIDTH(W), .DEPTH(D), .FWFT(1)) u_fwft (
        .clk(clk), .reset(reset), .wdata(wdata), .wr_en(wr_en), .rd_en(rd_en),
        .rdata(f_rdata), .rd_valid(f_rv), .empty(f_empty), .full(f_full),
        .almost_empty(f_ae), .almost_full(f_af), .count(f_count),
        .wr_error(f_werr), .rd_error(f_rerr));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    int n_cmp = 0;
    int n_bad = 0;
    int step_no = 0;

    // Reference model state
    logic [W-1:0] mq[$];
    logic [W-1:0] m_std_rdata;
    logic         m_std_rv, m_werr, m_rerr;

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @step %0d: got %0h expected %0h", nm, step_no, act, exp);
        end
    endfunction

    function automatic void model_edge(logic r, logic we, logic [W-1:0] wd, logic re);
        logic isfull, isempty, wa, ra;
        if (r) begin
            mq.delete();
            m_std_rdata = '0;
            m_std_rv = 1'b0;
            m_werr = 1'b0;
            m_rerr = 1'b0;
        end else begin
            isfull  = (mq.size() == D);
            isempty = (mq.size() == 0);
            wa = we && !isfull;
            ra = re && !isempty;
            m_werr   = we && isfull;
            m_rerr   = re && isempty;
            m_std_rv = ra;
            if (ra) m_std_rdata = mq.pop_front();
            if (wa) mq.push_back(wd);
        end
    endfunction

    function automatic void check_model();
        int n;
        n = mq.size();
        chk("s_count", 32'(s_count), 32'(n));
        chk("s_empty", 32'(s_empty), 32'(n == 0));
        chk("s_full", 32'(s_full), 32'(n == D));
        chk("s_almost_empty", 32'(s_ae), 32'(n <= 2));
        chk("s_almost_full", 32'(s_af), 32'(n >= D - 2));
        chk("s_wr_error", 32'(s_werr), 32'(m_werr));
        chk("s_rd_error", 32'(s_rerr), 32'(m_rerr));
        chk("s_rdata", 32'(s_rdata), 32'(m_std_rdata));
        chk("s_rd_valid", 32'(s_rv), 32'(m_std_rv));
        chk("f_count", 32'(f_count), 32'(n));
        chk("f_flags", {28'd0, f_empty, f_full, f_ae, f_af},
            {28'd0, n == 0, n == D, n <= 2, n >= D - 2});
        chk("f_errors", {30'd0, f_werr, f_rerr}, {30'd0, m_werr, m_rerr});
        chk("f_rd_valid", 32'(f_rv), 32'(n != 0));
        chk("f_rdata", 32'(f_rdata), (n != 0) ? 32'(mq[0]) : 32'd0);
    endfunction

    // One clock: apply inputs, advance the model at the edge, check 1 ns later.
    task automatic step(input logic r, input logic we, input logic [W-1:0] wd, input logic re);
        reset = r; wr_en = we; wdata = wd; rd_en = re;
        @(posedge clk);
        model_edge(r, we, wd, re);
        #1;
        step_no++;
        check_model();
    endtask

    typedef struct {
        logic       rst, we;
        logic [7:0] wd;
        logic       re;
        logic [4:0] cnt;
        logic       emp, ful;
        logic [7:0] rd;
        logic       rv, werr, rerr;
    } vec_t;

    vec_t tbl[12];

    initial begin
        // rst we wd re | cnt emp full rdata rv werr rerr  (standard instance)
        tbl[0]  = '{1'b1, 1'b0, 8'h00, 1'b0, 5'd0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0};
        tbl[1]  = '{1'b0, 1'b0, 8'h00, 1'b1, 5'd0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1};
        tbl[2]  = '{1'b0, 1'b1, 8'h3C, 1'b1, 5'd1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1};
        tbl[3]  = '{1'b0, 1'b0, 8'h00, 1'b1, 5'd0, 1'b1, 1'b0, 8'h3C, 1'b1, 1'b0, 1'b0};
        tbl[4]  = '{1'b0, 1'b1, 8'h11, 1'b0, 5'd1, 1'b0, 1'b0, 8'h3C, 1'b0, 1'b0, 1'b0};
        tbl[5]  = '{1'b0, 1'b1, 8'h22, 1'b0, 5'd2, 1'b0, 1'b0, 8'h3C, 1'b0, 1'b0, 1'b0};
        tbl[6]  = '{1'b0, 1'b1, 8'h33, 1'b1, 5'd2, 1'b0, 1'b0, 8'h11, 1'b1, 1'b0, 1'b0};
        tbl[7]  = '{1'b0, 1'b0, 8'h00, 1'b0, 5'd2, 1'b0, 1'b0, 8'h11, 1'b0, 1'b0, 1'b0};
        tbl[8]  = '{1'b0, 1'b0, 8'h00, 1'b1, 5'd1, 1'b0, 1'b0, 8'h22, 1'b1, 1'b0, 1'b0};
        tbl[9]  = '{1'b0, 1'b0, 8'h00, 1'b1, 5'd0, 1'b1, 1'b0, 8'h33, 1'b1, 1'b0, 1'b0};
        tbl[10] = '{1'b0, 1'b0, 8'h00, 1'b1, 5'd0, 1'b1, 1'b0, 8'h33, 1'b0, 1'b0, 1'b1};
        tbl[11] = '{1'b1, 1'b1, 8'h77, 1'b1, 5'd0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0};

        reset = 1'b1; wr_en = 1'b0; rd_en = 1'b0; wdata = '0;
        m_std_rdata = '0; m_std_rv = 1'b0; m_werr = 1'b0; m_rerr = 1'b0;

        // Table vectors
        for (int i = 0; i < 12; i++) begin
            step(tbl[i].rst, tbl[i].we, tbl[i].wd, tbl[i].re);
            chk("tbl_count", 32'(s_count), 32'(tbl[i].cnt));
            chk("tbl_flags", {30'd0, s_empty, s_full}, {30'd0, tbl[i].emp, tbl[i].ful});
            chk("tbl_rdata", 32'(s_rdata), 32'(tbl[i].rd));
            chk("tbl_rd_valid", 32'(s_rv), 32'(tbl[i].rv));
            chk("tbl_errors", {30'd0, s_werr, s_rerr}, {30'd0, tbl[i].werr, tbl[i].rerr});
        end

        // Fill 0x01..0x10 and watch the threshold flags
        step(1'b1, 1'b0, 8'h00, 1'b0);
        for (int i = 1; i <= 16; i++) begin
            step(1'b0, 1'b1, 8'(i), 1'b0);
            chk("fill_empty", 32'(s_empty), 32'd0);
            chk("fill_ae", 32'(s_ae), 32'(i <= 2));
            chk("fill_af", 32'(s_af), 32'(i >= 14));
            chk("fill_full", 32'(s_full), 32'(i == 16));
        end
        chk("fill_count", 32'(s_count), 32'd16);

        // Overflow attempt, then drain in order
        step(1'b0, 1'b1, 8'hFF, 1'b0);
        chk("ovf_wr_error", 32'(s_werr), 32'd1);
        chk("ovf_count", 32'(s_count), 32'd16);
        step(1'b0, 1'b0, 8'h00, 1'b0);
        chk("ovf_wr_error_pulse", 32'(s_werr), 32'd0);
        for (int i = 1; i <= 16; i++) begin
            step(1'b0, 1'b0, 8'h00, 1'b1);
            chk("drain_rdata", 32'(s_rdata), 32'(i));
            chk("drain_rd_valid", 32'(s_rv), 32'd1);
        end
        step(1'b0, 1'b0, 8'h00, 1'b0);
        chk("drain_empty", 32'(s_empty), 32'd1);
        chk("drain_rv_low", 32'(s_rv), 32'd0);

        // Steady state at count 5 with simultaneous read/write across wrap
        step(1'b1, 1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 8'(8'h40 + i), 1'b0);
        for (int k = 0; k < 20; k++) begin
            step(1'b0, 1'b1, 8'(8'h50 + k), 1'b1);
            chk("rw_count", 32'(s_count), 32'd5);
            chk("rw_rdata", 32'(s_rdata), (k < 5) ? 32'(8'h40 + k) : 32'(8'h50 + k - 5));
        end

        // FWFT: word written into empty FIFO appears without rd_en
        step(1'b1, 1'b0, 8'h00, 1'b0);
        step(1'b0, 1'b1, 8'hA5, 1'b0);
        chk("fwft_rdata", 32'(f_rdata), 32'hA5);
        chk("fwft_rv", 32'(f_rv), 32'd1);
        step(1'b0, 1'b0, 8'h00, 1'b0);
        chk("fwft_hold", 32'(f_rdata), 32'hA5);
        step(1'b0, 1'b0, 8'h00, 1'b1);
        chk("fwft_pop_empty", 32'(f_empty), 32'd1);
        chk("fwft_pop_rv", 32'(f_rv), 32'd0);
        chk("fwft_pop_rdata", 32'(f_rdata), 32'd0);

        // Reset at count 7 discards contents
        for (int i = 0; i < 7; i++) step(1'b0, 1'b1, 8'(8'hC0 + i), 1'b0);
        chk("pre_rst_count", 32'(s_count), 32'd7);
        step(1'b1, 1'b1, 8'h99, 1'b1);
        chk("rst_count", 32'(s_count), 32'd0);
        chk("rst_outs", {27'd0, s_empty, s_werr, s_rerr, s_rv, f_rv},
            {27'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0});
        step(1'b0, 1'b1, 8'h11, 1'b0);
        chk("rst_fwft_new", 32'(f_rdata), 32'h11);
        step(1'b0, 1'b0, 8'h00, 1'b1);
        chk("rst_std_new", 32'(s_rdata), 32'h11);

        // Randomized traffic with varying read/write bias
        for (int p = 0; p < 10; p++) begin
            int wb, rb;
            case (p % 4)
                0: begin wb = 80; rb = 20; end
                1: begin wb = 20; rb = 80; end
                2: begin wb = 50; rb = 50; end
                default: begin wb = 95; rb = 95; end
            endcase
            for (int k = 0; k < 200; k++) begin
                step($urandom_range(0, 199) == 0,
                     $urandom_range(0, 99) < wb,
                     8'($urandom),
                     $urandom_range(0, 99) < rb);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
